// File: rtl/btn_debounce_pulse_if.sv
// rtl/btn_debounce_pulse_if.sv - raw button pins and conditioned level/pulse outputs
interface btn_debounce_pulse_if #(
  parameter int N = 2
);
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic [N-1:0] btn_long;

  modport master (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_long
  );

  modport slave (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_long
  );
endinterface

// File: rtl/btn_debounce_pulse.sv
// rtl/btn_debounce_pulse.sv - per-channel synchroniser, debouncer, press/release/long pulses
module btn_debounce_pulse #(
  parameter int N               = 2,
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int LONG_CYCLES     = 1000000
) (
  input  logic                  clk0,
  input  logic                  rst_n,
  btn_debounce_pulse_if.master  bus
);

  localparam int MAXC = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
  localparam int CW   = $clog2(MAXC);
  localparam logic [CW-1:0] D_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] H_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  logic [N-1:0]  sync1_q, sync2_q;
  state_t        state_q [N];
  state_t        state_d [N];
  logic [CW-1:0] dcnt_q  [N];
  logic [CW-1:0] dcnt_d  [N];
  logic [CW-1:0] hcnt_q  [N];
  logic [CW-1:0] hcnt_d  [N];
  logic [N-1:0]  long_done_q, long_done_d;
  logic [N-1:0]  level_q, level_d;
  logic [N-1:0]  press_q, press_d;
  logic [N-1:0]  release_q, release_d;
  logic [N-1:0]  long_q, long_d;

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      long_done_q <= '0;
      level_q     <= '0;
      press_q     <= '0;
      release_q   <= '0;
      long_q      <= '0;
      for (int i = 0; i < N; i++) begin
        state_q[i] <= IDLE;
        dcnt_q[i]  <= '0;
        hcnt_q[i]  <= '0;
      end
    end else begin
      sync1_q     <= bus.btn_raw;
      sync2_q     <= sync1_q;
      long_done_q <= long_done_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        dcnt_q[i]  <= dcnt_d[i];
        hcnt_q[i]  <= hcnt_d[i];
      end
    end
  end

  always_comb begin
    long_done_d = long_done_q;
    level_d     = '0;
    press_d     = '0;
    release_d   = '0;
    long_d      = '0;
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      dcnt_d[i]  = dcnt_q[i];
      hcnt_d[i]  = hcnt_q[i];
      case (state_q[i])
        IDLE: begin
          if (sync2_q[i]) begin
            state_d[i] = PRESS_WAIT;
            dcnt_d[i]  = '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync2_q[i]) begin
            state_d[i] = IDLE;
          end else if (dcnt_q[i] == D_LAST) begin
            state_d[i] = PRESSED;
            press_d[i] = 1'b1;
            hcnt_d[i]  = '0;
          end else begin
            dcnt_d[i] = dcnt_q[i] + ONE;
          end
        end
        PRESSED: begin
          if (!sync2_q[i]) begin
            state_d[i] = RELEASE_WAIT;
            dcnt_d[i]  = '0;
          end else if (!long_done_q[i] && (hcnt_q[i] == H_LAST)) begin
            long_d[i]      = 1'b1;
            long_done_d[i] = 1'b1;
          end else if (!long_done_q[i]) begin
            hcnt_d[i] = hcnt_q[i] + ONE;
          end
        end
        RELEASE_WAIT: begin
          // Hold time is paused, not reset, so a bounce does not restart the long-press timer
          if (sync2_q[i]) begin
            state_d[i] = PRESSED;
          end else if (dcnt_q[i] == D_LAST) begin
            state_d[i]     = IDLE;
            release_d[i]   = 1'b1;
            long_done_d[i] = 1'b0;
            hcnt_d[i]      = '0;
          end else begin
            dcnt_d[i] = dcnt_q[i] + ONE;
          end
        end
        default: state_d[i] = IDLE;
      endcase
      level_d[i] = (state_d[i] == PRESSED) || (state_d[i] == RELEASE_WAIT);
    end
  end

  assign bus.btn_level   = level_q;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = release_q;
  assign bus.btn_long    = long_q;

endmodule
